// File: rtl/seq_prefix_multiplier.sv
// seq_prefix_multiplier: running product of a gate sequence from the top index down,
// caching every prefix so a sequence sharing a prefix only multiplies its changed suffix.
module seq_prefix_multiplier #(
  parameter int NUMERIC_BITS = 19,
  parameter int SEQ_INDEX_BITS = 5,
  parameter int DEPTH = 8,
  parameter int GATE_BITS = 5,
  parameter int STAT_BITS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic seq_valid,
  output logic seq_ready,
  input  logic [SEQ_INDEX_BITS-1:0] seq_index,
  input  logic [GATE_BITS-1:0] seq_gate,
  input  logic seq_first,
  output logic [8*NUMERIC_BITS-1:0] result_mtx,
  output logic result_valid,
  output logic seq_err,
  output logic gt_req,
  output logic [GATE_BITS-1:0] gt_gate,
  input  logic gt_ack,
  input  logic [8*NUMERIC_BITS-1:0] gt_mtx,
  output logic mul_start,
  output logic [8*NUMERIC_BITS-1:0] mul_a,
  output logic [8*NUMERIC_BITS-1:0] mul_b,
  input  logic mul_done,
  input  logic [8*NUMERIC_BITS-1:0] mul_result,
  output logic [STAT_BITS-1:0] hit_count,
  output logic [STAT_BITS-1:0] mul_count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int MW = 8*NUMERIC_BITS;
  localparam logic [SEQ_INDEX_BITS:0] DL = (SEQ_INDEX_BITS+1)'(DEPTH);
  localparam logic [DEPTH-1:0] ONE_D = 1;
  typedef enum logic [1:0] {IDLE, FETCH, MUL, WRITE} state_t;
  state_t state, state_d;
  logic [MW-1:0] mtx [DEPTH];
  logic [GATE_BITS-1:0] tag [DEPTH];
  logic [DEPTH-1:0] root, vld, below;
  logic [MW-1:0] g_mtx;
  logic [GATE_BITS-1:0] g_tag, gate_r;
  logic g_vld, first_r, flush_pend;
  logic [AW-1:0] idx_r, ia, na;
  logic [SEQ_INDEX_BITS:0] ix, nx;
  logic err, hit, acc, do_flush, wr;
  assign ix = {1'b0, seq_index};
  assign nx = ix + (SEQ_INDEX_BITS+1)'(1);
  assign ia = seq_index[AW-1:0];
  assign na = nx[AW-1:0];
  // a non-root item needs the prefix one index above it to already be cached
  assign err = !(ix < DL) || (!seq_first && (!(nx < DL) || !vld[na]));
  assign hit = vld[ia] && tag[ia] == seq_gate && root[ia] == seq_first;
  assign below = (ONE_D << ia) - ONE_D;
  assign do_flush = state == IDLE && (flush || flush_pend);
  assign seq_ready = state == IDLE && !do_flush;
  assign acc = seq_valid && seq_ready;
  assign wr = (state == MUL && mul_done) || state == WRITE;
  assign gt_req = state == FETCH;
  assign gt_gate = gate_r;
  assign mul_a = mtx[idx_r + AW'(1)];
  assign mul_b = g_mtx;
  assign result_mtx = mtx[0];
  always_comb begin
    state_d = state;
    if (acc && !err && !hit) state_d = g_vld && g_tag == seq_gate ? (seq_first ? WRITE : MUL) : FETCH;
    if (state == FETCH && gt_ack) state_d = first_r ? WRITE : MUL;
    if (state == MUL && mul_done) state_d = IDLE;
    if (state == WRITE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      vld <= '0;
      g_vld <= 1'b0;
      flush_pend <= 1'b0;
      result_valid <= 1'b0;
      seq_err <= 1'b0;
      mul_start <= 1'b0;
      hit_count <= '0;
      mul_count <= '0;
    end else begin
      state <= state_d;
      result_valid <= (wr && idx_r == '0) || (acc && !err && hit && ia == '0);
      seq_err <= acc && err;
      mul_start <= state != MUL && state_d == MUL;
      if (mul_start && ~&mul_count) mul_count <= mul_count + STAT_BITS'(1);
      if (acc && !err && hit && ~&hit_count) hit_count <= hit_count + STAT_BITS'(1);
      if (acc) begin
        idx_r <= ia;
        gate_r <= seq_gate;
        first_r <= seq_first;
      end
      if (acc && !err && !hit) vld <= vld & ~below;
      if (state == FETCH && gt_ack) begin
        g_mtx <= gt_mtx;
        g_tag <= gate_r;
        g_vld <= 1'b1;
      end
      if (wr) vld[idx_r] <= 1'b1;
      if (do_flush) begin
        vld <= '0;
        g_vld <= 1'b0;
        flush_pend <= 1'b0;
      end else if (flush && state != IDLE) flush_pend <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !reset) begin
      mtx[idx_r] <= state == WRITE ? g_mtx : mul_result;
      tag[idx_r] <= gate_r;
      root[idx_r] <= first_r;
    end
  end
endmodule

// File: tb/tb_seq_prefix_multiplier.sv
// tb_seq_prefix_multiplier: directed and random gate sequences against a prefix-path model,
// with the bench acting as gate table and complex matrix multiplier.
module tb_seq_prefix_multiplier;
  localparam int NB = 19, SB = 5, D = 8, GB = 5, STB = 16, MW = 8*NB, FRAC = 14;
  logic clk = 0, reset = 1, flush = 0, seq_valid = 0, seq_first = 0, gt_ack = 0, mul_done = 0;
  logic [SB-1:0] seq_index = '0;
  logic [GB-1:0] seq_gate = '0;
  logic [MW-1:0] gt_mtx = '0, mul_result = '0;
  logic seq_ready, result_valid, seq_err, gt_req, mul_start;
  logic [GB-1:0] gt_gate;
  logic [MW-1:0] result_mtx, mul_a, mul_b;
  logic [STB-1:0] hit_count, mul_count;

  seq_prefix_multiplier #(.NUMERIC_BITS(NB), .SEQ_INDEX_BITS(SB), .DEPTH(D), .GATE_BITS(GB), .STAT_BITS(STB)) dut (
    .clk(clk), .reset(reset), .flush(flush), .seq_valid(seq_valid), .seq_ready(seq_ready),
    .seq_index(seq_index), .seq_gate(seq_gate), .seq_first(seq_first), .result_mtx(result_mtx),
    .result_valid(result_valid), .seq_err(seq_err), .gt_req(gt_req), .gt_gate(gt_gate),
    .gt_ack(gt_ack), .gt_mtx(gt_mtx), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result), .hit_count(hit_count), .mul_count(mul_count));

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0, fetch_cnt = 0, mulop_cnt = 0;
  int rv_cnt = 0, err_cnt = 0, cyc = 0, rv_cyc = 0;
  logic [MW-1:0] rv_mtx = '0, ma, mb;
  bit auto_en = 1;
  logic [MW-1:0] tab [32];
  bit m_has [D+1];
  string m_path [D+1];
  logic [MW-1:0] m_prod [D+1];
  bit m_gv = 0;
  int m_g = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (result_valid) begin
      rv_cnt <= rv_cnt + 1;
      rv_mtx <= result_mtx;
      rv_cyc <= cyc;
    end
    if (seq_err) err_cnt <= err_cnt + 1;
  end

  function automatic longint el(input logic [MW-1:0] m, input int r, input int c, input int p);
    return longint'($signed(m[(r*4+c*2+p)*NB +: NB]));
  endfunction

  // fixed-point complex 2x2 product, the behaviour the bench gives the shared multiplier
  function automatic logic [MW-1:0] mult(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0] y;
    longint re, im;
    y = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        re = 0;
        im = 0;
        for (int k = 0; k < 2; k++) begin
          re += el(a,r,k,0)*el(b,k,c,0) - el(a,r,k,1)*el(b,k,c,1);
          im += el(a,r,k,0)*el(b,k,c,1) + el(a,r,k,1)*el(b,k,c,0);
        end
        y[(r*4+c*2)*NB +: NB] = NB'(re >>> FRAC);
        y[(r*4+c*2+1)*NB +: NB] = NB'(im >>> FRAC);
      end
    return y;
  endfunction

  initial forever begin
    @(negedge clk);
    if (auto_en && gt_req) begin
      @(negedge clk);
      gt_mtx = tab[gt_gate];
      gt_ack = 1;
      @(negedge clk);
      gt_ack = 0;
      fetch_cnt++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (auto_en && mul_start) begin
      ma = mul_a;
      mb = mul_b;
      @(negedge clk);
      mul_result = mult(ma, mb);
      mul_done = 1;
      @(negedge clk);
      mul_done = 0;
      mulop_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!seq_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 152'(t < 40), 1);
  endtask

  task automatic model_clear();
    for (int i = 0; i <= D; i++) m_has[i] = 0;
    m_gv = 0;
  endtask

  task automatic send(input int idx, input int g, input bit f, input bit fl = 0);
    int h0, m0, f0, u0, r0, e0, ac, t;
    bit ex_err, ex_hit, ex_miss;
    string cur;
    logic [MW-1:0] prod;
    h0 = hit_count; m0 = mul_count; f0 = fetch_cnt; u0 = mulop_cnt; r0 = rv_cnt; e0 = err_cnt;
    ex_err = idx >= D || (!f && (idx + 1 >= D || !m_has[idx+1]));
    ex_hit = 0;
    cur = "";
    prod = '0;
    if (!ex_err) begin
      cur = f ? $sformatf("R%0d", g) : {m_path[idx+1], $sformatf(".%0d", g)};
      ex_hit = m_has[idx] && m_path[idx] == cur;
      prod = f ? tab[g] : mult(m_prod[idx+1], tab[g]);
    end
    ex_miss = !ex_err && !ex_hit;
    wait_idle();
    seq_index = SB'(idx);
    seq_gate = GB'(g);
    seq_first = f;
    seq_valid = 1;
    ac = cyc;
    @(posedge clk);
    #1 seq_valid = 0;
    if (fl) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!mul_start && t < 20);
      chk("mul_start_timeout", 152'(t < 20), 1);
      flush = 1;
      @(negedge clk);
      flush = 0;
    end
    @(negedge clk);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hit_count", hit_count, h0 + int'(ex_hit));
    chk("mul_count", mul_count, m0 + int'(ex_miss && !f));
    chk("fetches", fetch_cnt, f0 + int'(ex_miss && !(m_gv && m_g == g)));
    chk("mul_ops", mulop_cnt, u0 + int'(ex_miss && !f));
    chk("seq_err", err_cnt, e0 + int'(ex_err));
    chk("result_valid", rv_cnt, r0 + int'(!ex_err && idx == 0));
    if (!ex_err && idx == 0) chk("result_mtx", rv_mtx, prod);
    if (ex_hit && idx == 0) chk("hit_latency", rv_cyc, ac + 1);
    if (ex_miss) begin
      m_has[idx] = 1;
      m_path[idx] = cur;
      m_prod[idx] = prod;
      for (int i = 0; i < idx; i++) m_has[i] = 0;
      m_gv = 1;
      m_g = g;
    end
    if (fl) model_clear();
  endtask

  initial begin
    int len, plen;
    int cur [D], prev [D];
    for (int i = 0; i < 32; i++)
      for (int e = 0; e < 8; e++) tab[i][e*NB +: NB] = NB'(int'($urandom_range(0, 32768)) - 16384);
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_seq_ready", seq_ready, 1);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_gt_req", gt_req, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_mul_count", mul_count, 0);
    reset = 0;
    @(negedge clk);
    send(2, 3, 1); send(1, 5, 0); send(0, 7, 0);
    chk("seq1_mul_count", mul_count, 2);
    chk("seq1_hit_count", hit_count, 0);
    send(2, 3, 1); send(1, 5, 0); send(0, 7, 0);
    chk("seq2_hit_count", hit_count, 3);
    send(2, 3, 1); send(1, 6, 0); send(0, 7, 0);
    chk("seq3_mul_count", mul_count, 4);
    send(3, 1, 0);
    send(8, 1, 1);
    chk("err_keeps_result", result_mtx, m_prod[0]);
    chk("err_keeps_muls", mul_count, 4);
    send(1, 5, 0, 1);
    send(2, 3, 1); send(1, 5, 0); send(0, 7, 0);
    plen = 0;
    repeat (30) begin
      if ($urandom_range(0, 1) == 1 && plen > 0) begin
        len = plen;
        cur = prev;
        cur[$urandom_range(0, len - 1)] = $urandom_range(0, 3);
      end else begin
        len = $urandom_range(1, D);
        for (int i = 0; i < D; i++) cur[i] = $urandom_range(0, 3);
      end
      for (int i = len - 1; i >= 0; i--) send(i, cur[i], i == len - 1);
      prev = cur;
      plen = len;
    end
    auto_en = 0;
    wait_idle();
    seq_index = 0;
    seq_gate = 9;
    seq_first = 1;
    seq_valid = 1;
    @(posedge clk);
    #1 seq_valid = 0;
    @(negedge clk);
    chk("fetch_before_reset", gt_req, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    gt_ack = 1;
    gt_mtx = tab[10];
    chk("abort_gt_req", gt_req, 0);
    chk("abort_seq_ready", seq_ready, 1);
    chk("abort_mul_start", mul_start, 0);
    chk("abort_hit_count", hit_count, 0);
    chk("abort_mul_count", mul_count, 0);
    @(negedge clk);
    gt_ack = 0;
    chk("late_ack_ready", seq_ready, 1);
    chk("late_ack_gt_req", gt_req, 0);
    model_clear();
    auto_en = 1;
    send(0, 9, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
